// File: rtl/int_wb_pkg.sv
// int_wb_pkg: shared types and constants for the integer write-back arbiter.
package int_wb_pkg;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        WB_SRC_PIPE = 1'b0,
        WB_SRC_DIV  = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] rd;
        logic [31:0]           data;
    } wb_req_t;
endpackage

// File: rtl/wb_hold_buffer.sv
// wb_hold_buffer: one-entry holding register for a divider result that lost arbitration.
module wb_hold_buffer
    import int_wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  capture_i,
    input  logic                  release_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic [XLEN-1:0]       data_i,
    output logic                  valid_o,
    output logic [REG_ADDR_W-1:0] rd_o,
    output logic [XLEN-1:0]       data_o
);
    logic                  valid_q, valid_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]       data_q, data_d;

    always_comb begin
        valid_d = capture_i ? 1'b1 : (release_i ? 1'b0 : valid_q);
        rd_d    = capture_i ? rd_i : rd_q;
        data_d  = capture_i ? data_i : data_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign rd_o    = rd_q;
    assign data_o  = data_q;
endmodule

// File: rtl/int_wb_arbiter.sv
// int_wb_arbiter: picks one register-file writer per cycle (pipeline WB vs divider).
// INT_WB_STARVE_GUARD_EN adds a starvation counter that stalls the pipeline for a held result.
module int_wb_arbiter
    import int_wb_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  reg_write_wb,
    input  logic [REG_ADDR_W-1:0] rd_wb,
    input  logic [XLEN-1:0]       result_wb,
    input  logic                  div_valid,
    input  logic [REG_ADDR_W-1:0] div_rd,
    input  logic [XLEN-1:0]       div_result,
    output logic                  div_ready,
    output logic                  reg_write_p_mux,
    output logic [REG_ADDR_W-1:0] waddr_wb,
    output logic [XLEN-1:0]       wdata_wb,
    output logic                  wb_src,
    output logic                  stall_wb
);
    logic                  hold_valid;
    logic [REG_ADDR_W-1:0] hold_rd;
    logic [XLEN-1:0]       hold_data;
    logic                  div_hs, g_pipe, g_hold, g_div;
    wb_src_e               src;

    assign div_ready = ~hold_valid;
    assign div_hs    = div_valid & div_ready;
    assign g_hold    = stall_wb | (~reg_write_wb & hold_valid);
    assign g_pipe    = ~stall_wb & reg_write_wb;
    assign g_div     = ~stall_wb & ~reg_write_wb & ~hold_valid & div_hs;

    always_comb begin
        waddr_wb        = g_pipe ? rd_wb : (g_hold ? hold_rd : (g_div ? div_rd : '0));
        wdata_wb        = g_pipe ? result_wb : (g_hold ? hold_data : (g_div ? div_result : '0));
        src             = (g_hold | g_div) ? WB_SRC_DIV : WB_SRC_PIPE;
        reg_write_p_mux = (g_pipe | g_hold | g_div) & (waddr_wb != '0);
    end

    assign wb_src = src;

    wb_hold_buffer #(.XLEN(XLEN)) u_hold (
        .clk       (clk),
        .reset_n   (reset_n),
        .capture_i (div_hs & ~g_div),
        .release_i (g_hold),
        .rd_i      (div_rd),
        .data_i    (div_result),
        .valid_o   (hold_valid),
        .rd_o      (hold_rd),
        .data_o    (hold_data)
    );

`ifdef INT_WB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;

    // Counter cannot pass the limit: reaching it forces the held grant, which clears it.
    always_comb begin
        starve_cnt_d = g_hold ? '0 : ((hold_valid & g_pipe) ? starve_cnt_q + 1'b1 : starve_cnt_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) starve_cnt_q <= '0;
        else          starve_cnt_q <= starve_cnt_d;
    end

    assign stall_wb = (starve_cnt_q == CW'(STARVE_LIMIT)) & hold_valid;
`else
    logic unused_limit;
    assign unused_limit = |STARVE_LIMIT;
    assign stall_wb     = 1'b0;
`endif

    // The scoreboard never lets a pipeline write race a held result to the same register.
    a_no_waw: assert property (@(posedge clk) disable iff (!reset_n)
        !(hold_valid & reg_write_wb & (rd_wb == hold_rd) & (rd_wb != '0)));
endmodule
